// File: rtl/fifo_wr_arb.sv
// Four-requester round-robin write arbiter for a single FIFO write port.
// A grantee keeps the port for up to burst_max accepted words or until it drops req.
module fifo_wr_arb #(
    parameter int width     = 8,
    parameter int burst_max = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*width-1:0] data_in,
    input  logic               fullN,
    output logic [3:0]         gnt,
    output logic               W_EN,
    output logic [width-1:0]   f_in,
    output logic               busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] last_ptr, last_ptr_nxt;
    logic [4:0] cnt, cnt_nxt;
    logic [1:0] gidx;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       any_req;
    logic       accept;
    logic       release_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            cnt      <= 5'd0;
            last_ptr <= 2'd3;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            cnt      <= cnt_nxt;
            last_ptr <= last_ptr_nxt;
        end
    end

    always_comb begin
        gidx = 2'd0;
        case (gnt)
            4'b0010: gidx = 2'd1;
            4'b0100: gidx = 2'd2;
            4'b1000: gidx = 2'd3;
            default: gidx = 2'd0;
        endcase
    end

    // Scanning from last_ptr+1 puts the previous grantee last, which also covers release-time regrants.
    always_comb begin
        winner = last_ptr;
        idx    = last_ptr;
        for (int k = 4; k >= 1; k--) begin
            idx = last_ptr + 2'(k);
            if (req[idx]) winner = idx;
        end
    end

    assign any_req     = |req;
    assign accept      = (state == GRANT) && req[gidx] && fullN;
    assign release_now = (state == GRANT) &&
                         ((accept && (cnt == 5'(burst_max - 1))) || !req[gidx]);

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        cnt_nxt      = cnt;
        last_ptr_nxt = last_ptr;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt    = GRANT;
                    gnt_nxt      = 4'b0001 << winner;
                    cnt_nxt      = 5'd0;
                    last_ptr_nxt = winner;
                end
            end
            GRANT: begin
                if (release_now) begin
                    cnt_nxt = 5'd0;
                    if (any_req) begin
                        gnt_nxt      = 4'b0001 << winner;
                        last_ptr_nxt = winner;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                    end
                end else if (accept) begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                cnt_nxt   = 5'd0;
            end
        endcase
    end

    always_comb begin
        W_EN = accept;
        busy = (state == GRANT);
        f_in = '0;
        if (gnt != 4'b0000) f_in = data_in[gidx*width +: width];
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: per-cycle grant/enable checks plus a scoreboard of written words.
module tb_fifo_wr_arb;

   typedef struct {
      logic [3:0] g;
      logic [7:0] d;
   } exp_t;

   logic        clock;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] data_in;
   logic        fullN;
   logic [3:0]  gnt;
   logic        W_EN;
   logic [7:0]  f_in;
   logic        busy;

   logic [7:0]  lane [4];
   exp_t        sb [$];
   int          vectors = 0;
   int          miscompares = 0;

   fifo_wr_arb #(.width(8), .burst_max(4)) dut (
      .clk(clock),
      .rst(rst),
      .req(req),
      .data_in(data_in),
      .fullN(fullN),
      .gnt(gnt),
      .W_EN(W_EN),
      .f_in(f_in),
      .busy(busy)
   );

   // Free-running write clock, 10 time units per cycle.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] g, input int ln);
      exp_t e;
      e.g = g;
      e.d = lane[ln];
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic f);
      @(posedge clock);
      #1;
      req   = r;
      fullN = f;
   endtask

   // One clock cycle of stimulus followed by mid-cycle checks of the control outputs.
   task automatic cyc(input logic [3:0] r, input logic f, input logic expWe, input logic [3:0] expGnt);
      applyStimulus(r, f);
      @(negedge clock);
      checkOutput("w_en", {7'd0, W_EN}, {7'd0, expWe});
      checkOutput("gnt", {4'd0, gnt}, {4'd0, expGnt});
      checkOutput("busy", {7'd0, busy}, {7'd0, (expGnt != 4'd0)});
      if (expGnt == 4'd0) checkOutput("f_in_idle", f_in, 8'h00);
   endtask

   // Monitor: every FIFO write must match the oldest expected word.
   always @(negedge clock) begin
      if (W_EN === 1'b1) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_write at %0t: got gnt %b f_in %h expected no write", $time, gnt, f_in);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("sb_gnt", {4'd0, gnt}, {4'd0, e.g});
            checkOutput("sb_f_in", f_in, e.d);
         end
      end
   end

   initial begin
      lane[0] = 8'hA0;
      lane[1] = 8'hB1;
      lane[2] = 8'hC2;
      lane[3] = 8'hD3;
      data_in = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      rst   = 1'b1;
      req   = 4'b0000;
      fullN = 1'b1;

      // Reset state.
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("rst_gnt", {4'd0, gnt}, 8'h00);
      checkOutput("rst_w_en", {7'd0, W_EN}, 8'h00);
      checkOutput("rst_busy", {7'd0, busy}, 8'h00);
      checkOutput("rst_f_in", f_in, 8'h00);
      @(posedge clock);
      #1 rst = 1'b0;

      // All four requesting: bursts of 4 rotate 0,1,2,3,0 with no bubble.
      cyc(4'hF, 1'b1, 1'b0, 4'h0);
      for (int k = 0; k < 16; k++) begin
         push(4'(1 << (k / 4)), k / 4);
         cyc(4'hF, 1'b1, 1'b1, 4'(1 << (k / 4)));
      end
      cyc(4'h0, 1'b1, 1'b0, 4'h1);

      // Sole requester 2 keeps the port across burst boundaries.
      cyc(4'h4, 1'b1, 1'b0, 4'h0);
      for (int k = 0; k < 12; k++) begin
         push(4'h4, 2);
         cyc(4'h4, 1'b1, 1'b1, 4'h4);
      end
      cyc(4'h0, 1'b1, 1'b0, 4'h4);

      // Backpressure after two accepts holds grant and count.
      cyc(4'h3, 1'b1, 1'b0, 4'h0);
      for (int k = 0; k < 2; k++) begin
         push(4'h1, 0);
         cyc(4'h3, 1'b1, 1'b1, 4'h1);
      end
      for (int k = 0; k < 3; k++) cyc(4'h3, 1'b0, 1'b0, 4'h1);
      for (int k = 0; k < 2; k++) begin
         push(4'h1, 0);
         cyc(4'h3, 1'b1, 1'b1, 4'h1);
      end
      push(4'h2, 1);
      cyc(4'h3, 1'b1, 1'b1, 4'h2);
      cyc(4'h0, 1'b1, 1'b0, 4'h2);

      // Requester 1 drops after one word; requester 3 takes over.
      cyc(4'h2, 1'b1, 1'b0, 4'h0);
      push(4'h2, 1);
      cyc(4'hA, 1'b1, 1'b1, 4'h2);
      cyc(4'h8, 1'b1, 1'b0, 4'h2);
      push(4'h8, 3);
      cyc(4'h8, 1'b1, 1'b1, 4'h8);
      cyc(4'h0, 1'b1, 1'b0, 4'h8);

      // Asynchronous reset in the middle of a burst from requester 2.
      cyc(4'h4, 1'b1, 1'b0, 4'h0);
      for (int k = 0; k < 2; k++) begin
         push(4'h4, 2);
         cyc(4'h4, 1'b1, 1'b1, 4'h4);
      end
      @(posedge clock);
      #1;
      req = 4'hF;
      rst = 1'b1;
      #1;
      checkOutput("async_gnt", {4'd0, gnt}, 8'h00);
      checkOutput("async_w_en", {7'd0, W_EN}, 8'h00);
      checkOutput("async_busy", {7'd0, busy}, 8'h00);
      @(posedge clock);
      #1 rst = 1'b0;
      @(negedge clock);
      checkOutput("post_rst_gnt", {4'd0, gnt}, 8'h00);
      push(4'h1, 0);
      cyc(4'hF, 1'b1, 1'b1, 4'h1);

      // req drop coinciding with fullN low releases to requester 2.
      cyc(4'h4, 1'b0, 1'b0, 4'h1);
      push(4'h4, 2);
      cyc(4'h4, 1'b1, 1'b1, 4'h4);
      cyc(4'h0, 1'b1, 1'b0, 4'h4);
      cyc(4'h0, 1'b1, 1'b0, 4'h0);

      repeat (2) @(posedge clock);
      checkOutput("sb_leftover", 8'(sb.size()), 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter `width`, default 8: data word width, matching the FIFO data width.
REQ-002 The block SHALL have parameter `burst_max`, default 4 (legal 1..16): maximum words accepted per grant.
REQ-003 Port `clk`: input, 1 bit; single clock, the FIFO write clock; all state SHALL be on its rising edge.
REQ-004 Port `rst`: input, 1 bit; reset SHALL be asynchronous and active-high.
REQ-005 Port `req`: input, 4 bits; req[i] high means requester i has a valid word on its data lane.
REQ-006 Port `data_in`: input, 4*width bits; lane i SHALL be bits [i*width +: width].
REQ-007 Port `fullN`: input, 1 bit; FIFO not-full flag, high means the FIFO can accept a word.
REQ-008 Port `gnt`: output, 4 bits; registered one-hot or zero grant.
REQ-009 Port `W_EN`: output, 1 bit; FIFO write enable.
REQ-010 Port `f_in`: output, width bits; FIFO write data.
REQ-011 Port `busy`: output, 1 bit; high while in GRANT.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE (gnt == 0) and GRANT (gnt one-hot).
REQ-013 In IDLE with req != 0, next cycle SHALL be GRANT with gnt set to the round-robin winner.
REQ-014 In IDLE with req == 0, the block SHALL stay in IDLE.
REQ-015 Round-robin winner SHALL be the first requester with req high, searching from (last_ptr+1) mod 4 upward with wrap.
REQ-016 last_ptr SHALL be updated to the granted index on every new grant.
REQ-017 A word SHALL be accepted in a cycle iff gnt[i] && req[i] && fullN, for the granted i.
REQ-018 W_EN SHALL be combinational and equal to the acceptance condition; f_in SHALL equal lane i of data_in for the granted i, or 0 when gnt == 0.
REQ-019 Write latency: a word accepted in cycle t SHALL be presented to the FIFO in cycle t, with zero pipeline stages.
REQ-020 A burst counter (5 bits) SHALL clear on each new grant and increment on each accepted word.
REQ-021 The grant SHALL be released at the clock edge ending a cycle in which either: a word is accepted and the counter equals burst_max-1; or req[i] of the granted requester is low.
REQ-022 On release, if any req bit is high, the next grant SHALL be issued on the same edge with no idle bubble.
REQ-023 For a release-time regrant, the current grantee SHALL take lowest priority and SHALL be regranted only if it is the sole requester.
REQ-024 On release with no req high, the block SHALL enter IDLE.
REQ-025 While fullN is low, gnt SHALL hold, the counter SHALL hold, and W_EN SHALL be 0; backpressure SHALL never cause a release.
REQ-026 If fullN and req[i] both drop in the same cycle, the req-drop release rule SHALL apply.
REQ-027 With burst_max == 1, every accepted word SHALL cause a release.
REQ-028 Requesters SHALL hold their data lane stable while req is high and not accepted; the block SHALL NOT check this.

Reset
REQ-029 While rst is high, and immediately on its assertion: state = IDLE, gnt = 0, counter = 0, last_ptr = 3 (so requester 0 has first priority), busy = 0, W_EN = 0, f_in = 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no W_EN pulse after assertion; the first grant after release SHALL follow REQ-013 from IDLE.

Verification
REQ-031 Scenario: after reset, req = 4'b1111 held, fullN = 1, burst_max = 4 -> gnt = 0001 for 4 W_EN cycles, then 0010, 0100, 1000, 0001, with no bubble between grants.
REQ-032 Scenario: req = 4'b0100 only, held, burst_max = 4 -> gnt = 0100 continuously; bursts of 4 back-to-back with the counter clearing each burst; W_EN high every cycle.
REQ-033 Scenario: gnt = 0001, fullN low for 3 cycles after 2 accepts -> gnt holds, W_EN = 0 for those 3 cycles, then exactly 2 more accepts, then release.
REQ-034 Scenario: gnt = 0010, req[1] drops after 1 accept while req[3] is high -> next cycle gnt = 1000 and last_ptr = 3.
REQ-035 Scenario: rst pulsed while gnt = 0100 mid-burst -> gnt, W_EN and busy go to 0 asynchronously; after reset, with req = 1111, the first grant is 0001.
REQ-036 Scenario: lane data = {8'hD3, 8'hC2, 8'hB1, 8'hA0} (lane 3 down to lane 0) with req = 1111 -> f_in sequence during W_EN matches A0 x4, B1 x4, C2 x4, D3 x4.
